// File: rtl/skid_pkg.sv
// Shared sizing and pointer helpers for skid_fifo and its storage array.
package skid_pkg;

   // Bits needed to hold an occupancy value in 0..depth.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address depth entries (at least one bit).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Advance a pointer, wrapping from depth-1 back to 0 for any depth.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/skid_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read.
// Ports:
//   clk            write clock
//   we/waddr/wdata write enable, address and data
//   raddr/rdata    combinational read address and data
// Contents are deliberately not reset.
module skid_mem import skid_pkg::*; #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer with DEPTH entries, optional zero-latency bypass
// when empty, occupancy/almost-full reporting and synchronous flush.
// Ports:
//   clk, arst_n           clock, asynchronous active-low reset
//   i_valid, in, o_ready  producer side (o_ready registered)
//   o_valid, out, i_ready consumer side (combinational in bypass mode)
//   flush                 discard all stored data this cycle
//   count, almost_full    stored entries and count >= AF_LEVEL (registered)
module skid_fifo import skid_pkg::*; #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned AF_LEVEL = DEPTH - 1
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [WIDTH-1:0]          in,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [WIDTH-1:0]          out,
   input  logic                      flush,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      almost_full
);

   localparam int unsigned CW = cnt_w(DEPTH);
   localparam int unsigned PW = ptr_w(DEPTH);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             o_ready_q, o_ready_d;
   logic             almost_full_q, almost_full_d;

   logic             bypass_path;
   logic             push;
   logic             pop;
   logic             store;
   logic             pop_from_store;
   logic [WIDTH-1:0] rdata;

   skid_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (store),
      .waddr (wr_ptr_q),
      .wdata (in),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // Handshake decode and output muxing.
   always_comb begin
      bypass_path    = 1'b0;
      o_valid        = 1'b0;
      out            = '0;
      push           = 1'b0;
      pop            = 1'b0;
      store          = 1'b0;
      pop_from_store = 1'b0;

      bypass_path = (BYPASS != 0) && (count_q == '0);

      // In bypass the offered word is only valid to the consumer once the
      // buffer itself is ready, so nothing escapes during reset.
      if (!flush) begin
         if (bypass_path) begin
            o_valid = i_valid && o_ready_q;
         end else begin
            o_valid = (count_q != '0);
         end
      end

      if (o_valid) begin
         out = bypass_path ? in : rdata;
      end

      push           = i_valid && o_ready_q && !flush;
      pop            = o_valid && i_ready;
      // A bypassed word consumed in the same cycle never touches storage.
      store          = push && !(bypass_path && i_ready);
      pop_from_store = pop && !bypass_path;
   end

   // Next-state for pointers, occupancy and flags.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      o_ready_d     = o_ready_q;
      almost_full_d = almost_full_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (store) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
         end
         if (pop_from_store) begin
            rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
         end
         count_d = count_q + CW'(store) - CW'(pop_from_store);
      end

      o_ready_d     = flush || (count_d < CW'(DEPTH));
      almost_full_d = !flush && (count_d >= CW'(AF_LEVEL));
   end

   // State registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         o_ready_q     <= 1'b0;
         almost_full_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         o_ready_q     <= o_ready_d;
         almost_full_q <= almost_full_d;
      end
   end

   assign o_ready     = o_ready_q;
   assign almost_full = almost_full_q;
   assign count       = count_q;

   // Protocol checks.
   a_no_push_full : assert property (@(posedge clk) disable iff (!arst_n)
      !(push && (count_q == CW'(DEPTH))));

   a_no_pop_invalid : assert property (@(posedge clk) disable iff (!arst_n)
      !(pop && !o_valid));

   a_out_stable : assert property (@(posedge clk) disable iff (!arst_n)
      (o_valid && !i_ready && !flush) |=> (flush || $stable(out)));

endmodule

// File: tb/tb_skid_fifo.sv
// Bench for skid_fifo: dut 0 is DEPTH=4 bypass, dut 1 is DEPTH=3 registered.
module tb_skid_fifo;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       iv   [2];
   logic       ir   [2];
   logic       fl   [2];
   logic [7:0] din  [2];
   logic       ov   [2];
   logic       ordy [2];
   logic       af   [2];
   logic [7:0] dout [2];
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   skid_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .AF_LEVEL(3)) u_dut_a (
      .clk(clk), .arst_n(arst_n), .i_valid(iv[0]), .o_ready(ordy[0]), .in(din[0]),
      .o_valid(ov[0]), .i_ready(ir[0]), .out(dout[0]), .flush(fl[0]),
      .count(cnt_a), .almost_full(af[0]));

   skid_fifo #(.WIDTH(8), .DEPTH(3), .BYPASS(0), .AF_LEVEL(2)) u_dut_b (
      .clk(clk), .arst_n(arst_n), .i_valid(iv[1]), .o_ready(ordy[1]), .in(din[1]),
      .o_valid(ov[1]), .i_ready(ir[1]), .out(dout[1]), .flush(fl[1]),
      .count(cnt_b), .almost_full(af[1]));

   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         r;
      bit         f;
      bit         e_ov;
      logic [7:0] e_out;
      bit         e_rdy;
      int         e_cnt;
      bit         e_af;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: stored words in arrival order plus the ready flag.
   logic [7:0] mq0[$];
   logic [7:0] mq1[$];
   bit         mrdy[2];

   function automatic logic [31:0] cnt_of(input int sel);
      return (sel == 0) ? 32'(cnt_a) : 32'(cnt_b);
   endfunction

   task automatic chk(input string name, input int sel, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, sel, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int sel, input bit e_ov, input logic [7:0] e_out,
                          input bit e_rdy, input int e_cnt, input bit e_af);
      chk({tag, ".o_valid"}, sel, 32'(ov[sel]), 32'(e_ov));
      chk({tag, ".out"}, sel, 32'(dout[sel]), 32'(e_out));
      chk({tag, ".o_ready"}, sel, 32'(ordy[sel]), 32'(e_rdy));
      chk({tag, ".count"}, sel, cnt_of(sel), 32'(e_cnt));
      chk({tag, ".almost_full"}, sel, 32'(af[sel]), 32'(e_af));
   endtask

   task automatic drive(input int sel, input bit v, input logic [7:0] d, input bit r, input bit f);
      iv[sel]  = v;
      din[sel] = d;
      ir[sel]  = r;
      fl[sel]  = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input bit v, input logic [7:0] d, input bit r, input bit f,
                               input bit e_ov, input logic [7:0] e_out, input bit e_rdy,
                               input int e_cnt, input bit e_af);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.f = f;
      t.e_ov = e_ov; t.e_out = e_out; t.e_rdy = e_rdy; t.e_cnt = e_cnt; t.e_af = e_af;
      return t;
   endfunction

   // One cycle of the queue model: check current outputs, then advance.
   task automatic model_step(input int sel);
      logic [7:0] q[$];
      int         depth;
      int         afl;
      bit         bp;
      bit         e_ov;
      bit         acc;
      bit         take;
      logic [7:0] e_out;
      if (sel == 0) q = mq0; else q = mq1;
      depth = (sel == 0) ? 4 : 3;
      afl   = (sel == 0) ? 3 : 2;
      bp    = (sel == 0) && (q.size() == 0);
      e_ov  = !fl[sel] && (bp ? (iv[sel] && mrdy[sel]) : (q.size() > 0));
      e_out = 8'h00;
      if (e_ov) e_out = bp ? din[sel] : q[0];
      chk_all("rand", sel, e_ov, e_out, mrdy[sel], q.size(), q.size() >= afl);
      acc  = iv[sel] && mrdy[sel] && !fl[sel];
      take = e_ov && ir[sel];
      if (fl[sel]) begin
         q.delete();
         mrdy[sel] = 1'b1;
      end else begin
         if (take && !bp) void'(q.pop_front());
         if (acc && !(bp && take)) q.push_back(din[sel]);
         mrdy[sel] = (q.size() < depth);
      end
      if (sel == 0) mq0 = q; else mq1 = q;
   endtask

   initial begin
      int thr;

      // Reset held with a word offered.
      arst_n = 1'b0;
      for (int s = 0; s < 2; s++) drive(s, 1'b1, 8'h33, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         for (int s = 0; s < 2; s++) chk_all("reset", s, 1'b0, 8'h00, 1'b0, 0, 1'b0);
      end
      for (int s = 0; s < 2; s++) drive(s, 1'b0, 8'h00, 1'b0, 1'b0);
      arst_n = 1'b1;
      #1;
      for (int s = 0; s < 2; s++) chk("release.o_ready_low", s, 32'(ordy[s]), 32'd0);
      tick();
      for (int s = 0; s < 2; s++) chk_all("release", s, 1'b0, 8'h00, 1'b1, 0, 1'b0);

      // Table on dut 0: bypass streaming, fill/drain, flush.
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1, 8'(8'h11 + k), 1, 0, 1, 8'(8'h11 + k), 1, 0, 0));
      tbl.push_back(mk(1, 8'hA0, 0, 0, 1, 8'hA0, 1, 0, 0));
      tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 8'hA0, 1, 1, 0));
      tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 8'hA0, 1, 2, 0));
      tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 8'hA0, 1, 3, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'hA0, 0, 4, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA0, 0, 4, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA1, 1, 3, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA2, 1, 2, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA3, 1, 1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(1, 8'hB0, 0, 0, 1, 8'hB0, 1, 0, 0));
      tbl.push_back(mk(1, 8'hB1, 0, 0, 1, 8'hB0, 1, 1, 0));
      tbl.push_back(mk(1, 8'hB2, 0, 0, 1, 8'hB0, 1, 2, 0));
      tbl.push_back(mk(1, 8'hFF, 0, 1, 0, 8'h00, 1, 3, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
      foreach (tbl[i]) begin
         drive(0, tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
         #1;
         chk_all($sformatf("vec%0d", i), 0, tbl[i].e_ov, tbl[i].e_out, tbl[i].e_rdy,
                 tbl[i].e_cnt, tbl[i].e_af);
         tick();
      end
      drive(0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Registered mode: one cycle from push to o_valid.
      drive(1, 1'b1, 8'h5A, 1'b1, 1'b0);
      #1;
      chk("reg.push_ov", 1, 32'(ov[1]), 32'd0);
      tick();
      drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      chk_all("reg.out", 1, 1'b1, 8'h5A, 1'b1, 1, 1'b0);
      tick();
      chk_all("reg.empty", 1, 1'b0, 8'h00, 1'b1, 0, 1'b0);

      // DEPTH=3: steady push+pop at count 2 wraps pointers, order preserved.
      for (int k = 0; k < 2; k++) begin
         drive(1, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         drive(1, 1'b1, 8'(8'hC2 + k), 1'b1, 1'b0);
         #1;
         chk_all("stream", 1, 1'b1, 8'(8'hC0 + k), 1'b1, 2, 1'b1);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
         #1;
         chk("stream.tail", 1, 32'(dout[1]), 32'(8'(8'hC0 + 20 + k)));
         tick();
      end
      chk_all("stream.empty", 1, 1'b0, 8'h00, 1'b1, 0, 1'b0);

      // DEPTH=3: fill, reject a push while full, drain in order.
      for (int k = 0; k < 3; k++) begin
         drive(1, 1'b1, 8'(8'hD0 + k), 1'b0, 1'b0);
         tick();
      end
      drive(1, 1'b1, 8'hD3, 1'b0, 1'b0);
      #1;
      chk_all("full", 1, 1'b1, 8'hD0, 1'b0, 3, 1'b1);
      tick();
      chk_all("full.hold", 1, 1'b1, 8'hD0, 1'b0, 3, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
         #1;
         chk("full.drain", 1, 32'(dout[1]), 32'(8'(8'hD0 + k)));
         tick();
      end
      chk_all("full.empty", 1, 1'b0, 8'h00, 1'b1, 0, 1'b0);

      // Randomised traffic against the queue model on both instances.
      for (int s = 0; s < 2; s++) drive(s, 1'b0, 8'h00, 1'b0, 1'b0);
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      mq0.delete();
      mq1.delete();
      mrdy[0] = 1'b0;
      mrdy[1] = 1'b0;
      thr = 50;
      for (int c = 0; c < 1200; c++) begin
         if (c % 100 == 0) thr = int'($urandom_range(10, 95));
         for (int s = 0; s < 2; s++)
            drive(s, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 99) < thr, $urandom_range(0, 39) == 0);
         #1;
         for (int s = 0; s < 2; s++) model_step(s);
         tick();
      end

      // Asynchronous reset while holding data.
      for (int s = 0; s < 2; s++) drive(s, 1'b1, 8'h77, 1'b0, 1'b0);
      tick();
      tick();
      arst_n = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) chk_all("async_rst", s, 1'b0, 8'h00, 1'b0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
